// File: rtl/matmul_stream_ctrl.sv
// Stream controller for a DIM x DIM systolic matrix multiply: loads A/B, feeds the array
// column/row vectors, waits out the array latency, snapshots and drains the result matrix.
module matmul_stream_ctrl #(
    parameter int DIM     = 2,
    parameter int DATA_W  = 32,
    parameter int ACC_W   = 32,
    parameter int ARR_LAT = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [DATA_W-1:0]        in_weight,
    input  logic                     acc_mode,
    output logic                     arr_clear,
    output logic                     arr_en,
    output logic [DIM*DATA_W-1:0]    arr_data,
    output logic [DIM*DATA_W-1:0]    arr_weight,
    input  logic [DIM*DIM*ACC_W-1:0] arr_result,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ACC_W-1:0]         out_data,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done
);
    localparam int NUM_EL = DIM * DIM;
    localparam int CNT_W  = $clog2(NUM_EL + 1);
    localparam int STEP_W = $clog2(DIM + ARR_LAT + 1);
    localparam logic [CNT_W-1:0]  EL_FULL    = CNT_W'(NUM_EL);
    localparam logic [CNT_W-1:0]  EL_LAST    = CNT_W'(NUM_EL - 1);
    localparam logic [STEP_W-1:0] FEED_LAST  = STEP_W'(DIM - 1);
    localparam logic [STEP_W-1:0] FLUSH_LAST = STEP_W'(DIM + ARR_LAT - 1);

    typedef enum logic [2:0] {StIdle, StLoad, StFeed, StFlush, StOut} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  load_idx_q, load_idx_d;
    logic [CNT_W-1:0]  out_idx_q, out_idx_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic              acc_q, acc_d;
    logic              snapshot;
    logic              load_fire, out_fire;

    logic [DATA_W-1:0] a_buf_q   [NUM_EL];
    logic [DATA_W-1:0] b_buf_q   [NUM_EL];
    logic [ACC_W-1:0]  res_buf_q [NUM_EL];

    logic in_ready_q, arr_clear_q, arr_en_q, out_valid_q, out_last_q, busy_q, done_q;

    assign load_fire = in_valid && in_ready_q;
    assign out_fire  = out_valid_q && out_ready;

    always_comb begin
        state_d    = state_q;
        load_idx_d = load_idx_q;
        out_idx_d  = out_idx_q;
        step_d     = step_q;
        acc_d      = acc_q;
        snapshot   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (load_fire) begin
                    state_d    = StLoad;
                    acc_d      = acc_mode;
                    load_idx_d = load_idx_q + 1'b1;
                end
            end
            StLoad: begin
                // A full buffer spends one cycle here with in_ready low before feeding.
                if (load_idx_q == EL_FULL) begin
                    state_d    = StFeed;
                    load_idx_d = '0;
                    step_d     = '0;
                end else if (load_fire) begin
                    load_idx_d = load_idx_q + 1'b1;
                end
            end
            StFeed: begin
                step_d = step_q + 1'b1;
                if (step_q == FEED_LAST) begin
                    state_d = StFlush;
                end
            end
            StFlush: begin
                if (step_q == FLUSH_LAST) begin
                    state_d   = StOut;
                    step_d    = '0;
                    out_idx_d = '0;
                    snapshot  = 1'b1;
                end else begin
                    step_d = step_q + 1'b1;
                end
            end
            StOut: begin
                if (out_fire) begin
                    if (out_idx_q == EL_LAST) begin
                        state_d   = StIdle;
                        out_idx_d = '0;
                    end else begin
                        out_idx_d = out_idx_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            load_idx_q  <= '0;
            out_idx_q   <= '0;
            step_q      <= '0;
            acc_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            arr_clear_q <= 1'b0;
            arr_en_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            load_idx_q  <= load_idx_d;
            out_idx_q   <= out_idx_d;
            step_q      <= step_d;
            acc_q       <= acc_d;
            // Control outputs are registered from the next state so they line up with it.
            in_ready_q  <= (state_d == StIdle || state_d == StLoad) && (load_idx_d != EL_FULL);
            arr_en_q    <= (state_d == StFeed) || (state_d == StFlush);
            arr_clear_q <= (state_d == StFeed) && (step_d == '0) && !acc_d;
            out_valid_q <= (state_d == StOut);
            out_last_q  <= (state_d == StOut) && (out_idx_d == EL_LAST);
            busy_q      <= (state_d != StIdle);
            done_q      <= (state_q == StOut) && out_fire && (out_idx_q == EL_LAST);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int e = 0; e < NUM_EL; e++) begin
                a_buf_q[e]   <= '0;
                b_buf_q[e]   <= '0;
                res_buf_q[e] <= '0;
            end
        end else begin
            for (int e = 0; e < NUM_EL; e++) begin
                if (load_fire && load_idx_q == CNT_W'(e)) begin
                    a_buf_q[e] <= in_data;
                    b_buf_q[e] <= in_weight;
                end
                if (snapshot) begin
                    res_buf_q[e] <= arr_result[e*ACC_W +: ACC_W];
                end
            end
        end
    end

    // Vector k: lane i carries A[i][k] and B[k][i].
    always_comb begin
        arr_data   = '0;
        arr_weight = '0;
        if (state_q == StFeed) begin
            for (int k = 0; k < DIM; k++) begin
                if (step_q == STEP_W'(k)) begin
                    for (int i = 0; i < DIM; i++) begin
                        arr_data[i*DATA_W +: DATA_W]   = a_buf_q[i*DIM + k];
                        arr_weight[i*DATA_W +: DATA_W] = b_buf_q[k*DIM + i];
                    end
                end
            end
        end
    end

    always_comb begin
        out_data = '0;
        if (state_q == StOut) begin
            for (int j = 0; j < NUM_EL; j++) begin
                if (out_idx_q == CNT_W'(j)) begin
                    out_data = res_buf_q[j];
                end
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign arr_clear = arr_clear_q;
    assign arr_en    = arr_en_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_matmul_stream_ctrl.sv
// Scoreboard bench for matmul_stream_ctrl: a DIM=2 instance with a behavioural array model
// covering accumulate, backpressure, load gaps and async reset, plus a DIM=4 instance.
module tb_matmul_stream_ctrl;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int D2 = 2;
    localparam int L2 = 3;
    localparam int D4 = 4;
    localparam int L4 = 7;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // DIM=2 instance
    logic                  a_in_valid, a_in_ready, a_acc_mode, a_arr_clear, a_arr_en;
    logic [DW-1:0]         a_in_data, a_in_weight;
    logic [D2*DW-1:0]      a_arr_data, a_arr_weight;
    logic [D2*D2*AW-1:0]   a_arr_result;
    logic                  a_out_valid, a_out_ready, a_out_last, a_busy, a_done;
    logic [AW-1:0]         a_out_data;

    matmul_stream_ctrl #(.DIM(D2), .DATA_W(DW), .ACC_W(AW), .ARR_LAT(L2)) u_dut2 (
        .clk(clk), .reset(reset),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .in_weight(a_in_weight), .acc_mode(a_acc_mode),
        .arr_clear(a_arr_clear), .arr_en(a_arr_en), .arr_data(a_arr_data),
        .arr_weight(a_arr_weight), .arr_result(a_arr_result),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_last(a_out_last), .busy(a_busy), .done(a_done)
    );

    // DIM=4 instance
    logic                  b_in_valid, b_in_ready, b_acc_mode, b_arr_clear, b_arr_en;
    logic [DW-1:0]         b_in_data, b_in_weight;
    logic [D4*DW-1:0]      b_arr_data, b_arr_weight;
    logic [D4*D4*AW-1:0]   b_arr_result;
    logic                  b_out_valid, b_out_ready, b_out_last, b_busy, b_done;
    logic [AW-1:0]         b_out_data;

    matmul_stream_ctrl #(.DIM(D4), .DATA_W(DW), .ACC_W(AW), .ARR_LAT(L4)) u_dut4 (
        .clk(clk), .reset(reset),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .in_weight(b_in_weight), .acc_mode(b_acc_mode),
        .arr_clear(b_arr_clear), .arr_en(b_arr_en), .arr_data(b_arr_data),
        .arr_weight(b_arr_weight), .arr_result(b_arr_result),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_last(b_out_last), .busy(b_busy), .done(b_done)
    );

    // Behavioural output-stationary arrays: C[i][j] += data[i] * weight[j] while enabled.
    logic [AW-1:0] a_acc [D2*D2];
    logic [AW-1:0] b_acc [D4*D4];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int e = 0; e < D2*D2; e++) a_acc[e] <= '0;
        end else if (a_arr_en) begin
            for (int i = 0; i < D2; i++)
                for (int j = 0; j < D2; j++)
                    a_acc[i*D2+j] <= (a_arr_clear ? '0 : a_acc[i*D2+j])
                                     + a_arr_data[i*DW +: DW] * a_arr_weight[j*DW +: DW];
        end
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int e = 0; e < D4*D4; e++) b_acc[e] <= '0;
        end else if (b_arr_en) begin
            for (int i = 0; i < D4; i++)
                for (int j = 0; j < D4; j++)
                    b_acc[i*D4+j] <= (b_arr_clear ? '0 : b_acc[i*D4+j])
                                     + b_arr_data[i*DW +: DW] * b_arr_weight[j*DW +: DW];
        end
    end

    always_comb begin
        a_arr_result = '0;
        for (int e = 0; e < D2*D2; e++) a_arr_result[e*AW +: AW] = a_acc[e];
    end

    always_comb begin
        b_arr_result = '0;
        for (int e = 0; e < D4*D4; e++) b_arr_result[e*AW +: AW] = b_acc[e];
    end

    int unsigned a_exp [$];
    int unsigned b_exp [$];
    int unsigned a_A [D2*D2];
    int unsigned a_B [D2*D2];
    int unsigned a_prev [D2*D2];
    int unsigned b_A [D4*D4];
    int unsigned b_B [D4*D4];
    int          a_t_last;
    int          a_clears = 0;
    logic        a_done_due = 1'b0;
    logic        a_hold = 1'b0;
    logic [AW-1:0] a_hold_data;
    logic        a_hold_last;
    int          b_feed = 0;
    bit          pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    always @(negedge clk) begin
        if (reset) begin
            a_done_due <= 1'b0;
            a_hold     <= 1'b0;
        end else begin
            if (a_done || a_done_due) check("a_done", a_done, a_done_due);
            a_done_due <= 1'b0;
            if (a_hold) begin
                check("a_hold_valid", a_out_valid, 1);
                check("a_hold_data", a_out_data, a_hold_data);
                check("a_hold_last", a_out_last, a_hold_last);
            end
            a_hold      <= a_out_valid && !a_out_ready;
            a_hold_data <= a_out_data;
            a_hold_last <= a_out_last;
            if (a_arr_clear && a_arr_en) a_clears <= a_clears + 1;
            if (a_arr_en || a_out_valid) check("a_in_ready_busy", a_in_ready, 0);
            if (a_out_valid && a_out_ready) begin
                if (a_exp.size() == 0) begin
                    check("a_extra_word", a_exp.size(), 1);
                end else begin
                    check("a_data", a_out_data, a_exp[0]);
                    check("a_last", a_out_last, a_exp.size() == 1);
                    a_done_due <= (a_exp.size() == 1);
                    void'(a_exp.pop_front());
                end
            end
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            b_feed <= 0;
        end else begin
            if (b_arr_en) begin
                for (int i = 0; i < D4; i++) begin
                    check("b_arr_data", b_arr_data[i*DW +: DW],
                          (b_feed < D4) ? b_A[i*D4 + b_feed] : 0);
                    check("b_arr_weight", b_arr_weight[i*DW +: DW],
                          (b_feed < D4) ? b_B[b_feed*D4 + i] : 0);
                end
                b_feed <= b_feed + 1;
            end else begin
                b_feed <= 0;
            end
            if (b_out_valid && b_out_ready) begin
                if (b_exp.size() == 0) begin
                    check("b_extra_word", b_exp.size(), 1);
                end else begin
                    check("b_data", b_out_data, b_exp[0]);
                    check("b_last", b_out_last, b_exp.size() == 1);
                    void'(b_exp.pop_front());
                end
            end
        end
    end

    task automatic a_load(input bit acc, input bit gaps);
        int n;
        int unsigned c;
        for (int i = 0; i < D2; i++) begin
            for (int j = 0; j < D2; j++) begin
                c = 0;
                for (int k = 0; k < D2; k++) c += a_A[i*D2+k] * a_B[k*D2+j];
                if (acc) c += a_prev[i*D2+j];
                a_prev[i*D2+j] = c;
                a_exp.push_back(c);
            end
        end
        for (int e = 0; e < D2*D2; e++) begin
            if (gaps) begin
                a_in_valid = 1'b0;
                @(posedge clk); #1;
            end
            a_in_valid  = 1'b1;
            a_in_data   = a_A[e];
            a_in_weight = a_B[e];
            a_acc_mode  = acc;
            n = 0;
            while (!a_in_ready && n < 50) begin
                @(posedge clk); #1;
                n++;
            end
            if (n == 50) check("a_load_timeout", n, 0);
            @(posedge clk); #1;
        end
        a_t_last   = cyc;
        a_in_valid = 1'b0;
    endtask

    task automatic a_wait_valid();
        int n = 0;
        while (!a_out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("a_latency", cyc - a_t_last, D2 + L2 + 1);
    endtask

    task automatic a_wait_idle();
        int n = 0;
        while ((a_busy || a_exp.size() != 0) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("a_drain", a_exp.size(), 0);
        @(posedge clk); #1;
        check("a_ready_after", a_in_ready, 1);
    endtask

    task automatic a_check_reset_outputs(input string tag);
        check(tag, {a_in_ready, a_arr_en, a_arr_clear, a_out_valid, a_out_last, a_busy, a_done}, 0);
        check("rst_a_vectors", {a_arr_data, a_arr_weight, a_out_data}, 0);
    endtask

    task automatic b_job();
        int n;
        int unsigned c;
        for (int i = 0; i < D4; i++) begin
            for (int j = 0; j < D4; j++) begin
                c = 0;
                for (int k = 0; k < D4; k++) c += b_A[i*D4+k] * b_B[k*D4+j];
                b_exp.push_back(c);
            end
        end
        for (int e = 0; e < D4*D4; e++) begin
            b_in_valid  = 1'b1;
            b_in_data   = b_A[e];
            b_in_weight = b_B[e];
            n = 0;
            while (!b_in_ready && n < 50) begin
                @(posedge clk); #1;
                n++;
            end
            if (n == 50) check("b_load_timeout", n, 0);
            @(posedge clk); #1;
        end
        b_in_valid = 1'b0;
        n = 0;
        while ((b_busy || b_exp.size() != 0) && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        check("b_drain", b_exp.size(), 0);
        check("b_done", b_done, 1);
    endtask

    initial begin
        int n;
        int v;
        int base;
        a_in_valid = 1'b0; a_in_data = '0; a_in_weight = '0; a_acc_mode = 1'b0;
        a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_data = '0; b_in_weight = '0; b_acc_mode = 1'b0;
        b_out_ready = 1'b1;
        a_A = '{1, 2, 3, 4};
        a_B = '{5, 6, 7, 8};
        for (int e = 0; e < D4*D4; e++) begin
            b_A[e] = (e / D4 == e % D4) ? 1 : 0;
            b_B[e] = e + 1;
        end

        repeat (3) @(posedge clk);
        #1;
        a_check_reset_outputs("rst_a_ctrl");
        check("rst_b_ctrl", {b_in_ready, b_arr_en, b_out_valid, b_busy, b_done}, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("a_ready_idle", a_in_ready, 1);
        check("a_busy_idle", a_busy, 0);

        // Plain job
        base = a_clears;
        a_load(1'b0, 1'b0);
        a_wait_valid();
        v = cyc;
        n = 0;
        while (!a_done && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("a_done_time", cyc - v, D2*D2);
        a_wait_idle();
        check("a_clear_job1", a_clears - base, 1);

        // Accumulate into the previous result
        base = a_clears;
        a_load(1'b1, 1'b0);
        a_wait_valid();
        a_wait_idle();
        check("a_clear_acc", a_clears - base, 0);

        // Output backpressure
        a_load(1'b0, 1'b0);
        n = 0;
        while ((a_busy || a_exp.size() != 0) && n < 200) begin
            a_out_ready = pat[n % 6];
            @(posedge clk); #1;
            n++;
        end
        check("a_bp_drain", a_exp.size(), 0);
        a_out_ready = 1'b1;
        @(posedge clk); #1;

        // Load gaps, then junk beats during FEED/FLUSH and a stalled OUT
        a_out_ready = 1'b0;
        a_load(1'b0, 1'b1);
        a_in_valid  = 1'b1;
        a_in_data   = 99;
        a_in_weight = 77;
        a_wait_valid();
        repeat (3) @(posedge clk);
        #1;
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        a_wait_idle();

        // Reset mid-FEED
        a_load(1'b0, 1'b0);
        @(posedge clk); #2;
        check("a_in_feed", a_arr_en, 1);
        reset = 1'b1;
        #1;
        a_check_reset_outputs("rst_mid_feed");
        a_exp.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        a_load(1'b0, 1'b0);
        a_wait_valid();
        a_wait_idle();

        // Reset mid-OUT
        a_out_ready = 1'b0;
        a_load(1'b0, 1'b0);
        a_wait_valid();
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        a_check_reset_outputs("rst_mid_out");
        a_exp.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        a_load(1'b0, 1'b0);
        a_wait_valid();
        a_wait_idle();

        // DIM=4, identity A
        b_job();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
